// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: 16 bits per clock, LSD first, with 4-bit lookahead groups
// and active-low word generate/propagate outputs for external carry-lookahead chaining.
module digit_serial_adder #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             nG,
    output logic             nP
);

    localparam int unsigned D  = WIDTH / 16;
    localparam int unsigned KW = (D > 1) ? $clog2(D) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [WIDTH-1:0] resReg;
    logic             carryReg;
    logic             gAcc;
    logic             pAcc;

    logic [15:0]      aDig;
    logic [15:0]      bDig;
    logic [15:0]      bitG;
    logic [15:0]      bitP;
    logic [3:0]       nGrpG;
    logic [3:0]       nGrpP;
    logic [4:0]       grpC;
    logic [16:0]      bitC;
    logic [15:0]      sumDig;
    logic             digG;
    logic             digP;
    logic             gAccNext;
    logic             pAccNext;
    logic [WIDTH-1:0] resNext;
    logic             lastDig;

    assign busy    = (state == RUN);
    assign lastDig = (k == KW'(D - 1));

    always_comb begin : digitPath
        logic rip;
        aDig = aReg[15:0];
        bDig = bReg[15:0];
        bitG = aDig & bDig;
        bitP = aDig | bDig;
        for (int unsigned i = 0; i < 4; i++) begin
            nGrpG[i] = ~(bitG[4*i+3]
                       | (bitP[4*i+3] & bitG[4*i+2])
                       | (bitP[4*i+3] & bitP[4*i+2] & bitG[4*i+1])
                       | (bitP[4*i+3] & bitP[4*i+2] & bitP[4*i+1] & bitG[4*i]));
            nGrpP[i] = ~(bitP[4*i+3] & bitP[4*i+2] & bitP[4*i+1] & bitP[4*i]);
        end

        grpC[0] = carryReg;
        grpC[1] = ~nGrpG[0] | (~nGrpP[0] & grpC[0]);
        grpC[2] = ~nGrpG[1] | (~nGrpP[1] & ~nGrpG[0]) | (~nGrpP[1] & ~nGrpP[0] & grpC[0]);
        grpC[3] = ~nGrpG[2] | (~nGrpP[2] & ~nGrpG[1]) | (~nGrpP[2] & ~nGrpP[1] & ~nGrpG[0])
                | (~nGrpP[2] & ~nGrpP[1] & ~nGrpP[0] & grpC[0]);
        grpC[4] = ~nGrpG[3] | (~nGrpP[3] & ~nGrpG[2]) | (~nGrpP[3] & ~nGrpP[2] & ~nGrpG[1])
                | (~nGrpP[3] & ~nGrpP[2] & ~nGrpP[1] & ~nGrpG[0])
                | (~nGrpP[3] & ~nGrpP[2] & ~nGrpP[1] & ~nGrpP[0] & grpC[0]);

        // Digit G/P exclude the incoming carry so the word terms never depend on cin.
        digG = ~nGrpG[3] | (~nGrpP[3] & ~nGrpG[2]) | (~nGrpP[3] & ~nGrpP[2] & ~nGrpG[1])
             | (~nGrpP[3] & ~nGrpP[2] & ~nGrpP[1] & ~nGrpG[0]);
        digP = ~|nGrpP;

        bitC = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            rip = grpC[i];
            for (int unsigned j = 0; j < 4; j++) begin
                bitC[4*i+j] = rip;
                rip = bitG[4*i+j] | (bitP[4*i+j] & rip);
            end
        end
        bitC[16] = grpC[4];

        sumDig = aDig ^ bDig ^ bitC[15:0];

        // Result register fills from the top; after D shifts digit 0 sits at the bottom.
        resNext = resReg >> 16;
        resNext[WIDTH-1 -: 16] = sumDig;

        gAccNext = digG | (digP & gAcc);
        pAccNext = pAcc & digP;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            k        <= '0;
            aReg     <= '0;
            bReg     <= '0;
            resReg   <= '0;
            carryReg <= 1'b0;
            gAcc     <= 1'b0;
            pAcc     <= 1'b1;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
            nG       <= 1'b1;
            nP       <= 1'b1;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    aReg     <= a;
                    bReg     <= sub ? ~b : b;
                    carryReg <= cin;
                    k        <= '0;
                    gAcc     <= 1'b0;
                    pAcc     <= 1'b1;
                    state    <= RUN;
                end
            end else begin
                aReg     <= aReg >> 16;
                bReg     <= bReg >> 16;
                resReg   <= resNext;
                carryReg <= grpC[4];
                gAcc     <= gAccNext;
                pAcc     <= pAccNext;
                k        <= k + 1'b1;
                if (lastDig) begin
                    state <= IDLE;
                    k     <= '0;
                    done  <= 1'b1;
                    sum   <= resNext;
                    cout  <= bitC[16];
                    ovf   <= bitC[15] ^ bitC[16];
                    zero  <= ~|resNext;
                    nG    <= ~gAccNext;
                    nP    <= ~pAccNext;
                end
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed self-checking bench for digit_serial_adder (WIDTH=64): vector table plus
// handshake sequences for held start, back-to-back issue and mid-operation reset.
module tb_digit_serial_adder;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic        cin;
        logic [63:0] s;
        logic        co;
        logic        ov;
        logic        z;
        logic        ng;
        logic        np;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        sub;
    logic        cin;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        nG;
    logic        nP;

    int tests;
    int fails;
    vec_t vecs[10];

    digit_serial_adder #(.WIDTH(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .sub     (sub),
        .cin     (cin),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .ovf     (ovf),
        .zero    (zero),
        .nG      (nG),
        .nP      (nP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Drive start for one edge, then wait (bounded) for done; returns edges after accept.
    task automatic runOp(input vec_t v, output int cyc);
        @(negedge clk);
        start = 1'b1;
        a = v.a;
        b = v.b;
        sub = v.sub;
        cin = v.cin;
        @(posedge clk);
        #1;
        chk("busyAccept", {63'd0, busy}, 64'd1);
        start = 1'b0;
        a = ~v.a;
        b = ~v.b;
        sub = ~v.sub;
        cin = ~v.cin;
        cyc = 0;
        while (!done && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic chkResult(input vec_t v, input string tag);
        chk({tag, ".sum"},  sum, v.s);
        chk({tag, ".cout"}, {63'd0, cout}, {63'd0, v.co});
        chk({tag, ".ovf"},  {63'd0, ovf},  {63'd0, v.ov});
        chk({tag, ".zero"}, {63'd0, zero}, {63'd0, v.z});
        chk({tag, ".nG"},   {63'd0, nG},   {63'd0, v.ng});
        chk({tag, ".nP"},   {63'd0, nP},   {63'd0, v.np});
        chk({tag, ".busyDone"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int cyc;
        int doneSeen;
        tests = 0;
        fails = 0;

        vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{64'h5, 64'h5, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{64'h3, 64'h5, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{64'h0, 64'h0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 64'h0001_0000_0001_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        reset_n = 1'b0;
        start = 1'b0;
        sub = 1'b0;
        cin = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", {63'd0, busy}, 64'd0);
        chk("rst.done", {63'd0, done}, 64'd0);
        chk("rst.sum",  sum, 64'd0);
        chk("rst.flags", {59'd0, cout, ovf, zero, nG, nP}, 64'b00011);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            runOp(vecs[i], cyc);
            chk($sformatf("v%0d.latency", i), 64'(cyc), 64'd4);
            chkResult(vecs[i], $sformatf("v%0d", i));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.donePulse", i), {63'd0, done}, 64'd0);
            chk($sformatf("v%0d.hold", i), sum, vecs[i].s);
        end

        // start held high through RUN with operands changing: only one operation.
        @(negedge clk);
        start = 1'b1;
        a = vecs[7].a;
        b = vecs[7].b;
        sub = vecs[7].sub;
        cin = vecs[7].cin;
        @(posedge clk);
        #1;
        a = 64'hDEAD_BEEF_DEAD_BEEF;
        b = 64'h1111_2222_3333_4444;
        cyc = 0;
        while (!done && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("held.latency", 64'(cyc), 64'd4);
        chkResult(vecs[7], "held");
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("held.noRerun", {62'd0, busy, done}, 64'd0);
        end

        // start during the done cycle is accepted on the following edge.
        runOp(vecs[0], cyc);
        chk("b2b.first.latency", 64'(cyc), 64'd4);
        chkResult(vecs[0], "b2b.first");
        @(negedge clk);
        start = 1'b1;
        a = vecs[9].a;
        b = vecs[9].b;
        sub = vecs[9].sub;
        cin = vecs[9].cin;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b.accept", {62'd0, busy, done}, 64'b10);
        chk("b2b.heldResult", sum, vecs[0].s);
        cyc = 0;
        while (!done && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("b2b.second.latency", 64'(cyc), 64'd4);
        chkResult(vecs[9], "b2b.second");

        // Reset pulsed mid-operation aborts without a done pulse.
        @(negedge clk);
        start = 1'b1;
        a = vecs[5].a;
        b = vecs[5].b;
        sub = vecs[5].sub;
        cin = vecs[5].cin;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort.busy", {63'd0, busy}, 64'd0);
        chk("abort.sum", sum, 64'd0);
        chk("abort.flags", {59'd0, cout, ovf, zero, nG, nP}, 64'b00011);
        @(negedge clk);
        reset_n = 1'b1;
        doneSeen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done || busy) doneSeen++;
        end
        chk("abort.noDone", 64'(doneSeen), 64'd0);
        runOp(vecs[3], cyc);
        chk("abort.next.latency", 64'(cyc), 64'd4);
        chkResult(vecs[3], "abort.next");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
